sd_blk_arbiter: RTL and testbench

//  Shares the single hps_io virtual-disk block channel between NREQ image users (FDD0, FDD1, SASI, NVRAM).

---
 rtl/sd_arb_pkg.sv | 15 +
 rtl/sd_blk_arbiter_rr_pick.sv | 34 +++
 rtl/sd_blk_arbiter.sv | 153 +++++++++++++++
 tb/tb_sd_blk_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and widths for the hps_io virtual-disk block-channel arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    DRAIN,
    IDLE,
    ISSUE,
    XFER
  } sd_arb_state_t;

  localparam int SD_LBA_W = 32;
  localparam int SD_BUF_W = 8;
  localparam int SD_IDX_W = 3;

endpackage

// File: rtl/sd_blk_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index strictly after i_last, wrapping,
// found by masking a doubled request vector and priority-encoding the lowest set bit.
module rr_pick
  import sd_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]     i_pending,
  input  logic [SD_IDX_W-1:0] i_last,
  output logic                o_valid,
  output logic [SD_IDX_W-1:0] o_index
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_masked;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_dbl    = {i_pending, i_pending};
    w_masked = '0;
    o_index  = '0;
    // The upper copy keeps i_last itself as the last candidate, so it has the lowest priority.
    for (int j = 0; j < 2 * NREQ; j++) begin
      w_masked[j] = w_dbl[j] && (j > int'(i_last));
    end
    o_valid = |w_masked;
    for (int j = 2 * NREQ - 1; j >= 0; j--) begin
      if (w_masked[j]) begin
        o_index = (j >= NREQ) ? SD_IDX_W'(j - NREQ) : SD_IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sd_blk_arbiter.sv
// Round-robin arbiter sharing the hps_io block channel between NREQ drive controllers.
// Define SD_ARB_TIMEOUT_EN to abort commands that see no sd_ack within TIMEOUT_CYC cycles.
module sd_blk_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NREQ        = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd4000000
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_rd,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*SD_LBA_W-1:0] req_lba,
  input  logic [NREQ*SD_BUF_W-1:0] req_buff_din,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          req_done,
  output logic [NREQ-1:0]          req_err,
  output logic [SD_LBA_W-1:0]      sd_lba,
  output logic [NREQ-1:0]          sd_rd,
  output logic [NREQ-1:0]          sd_wr,
  input  logic                     sd_ack,
  output logic [SD_BUF_W-1:0]      sd_buff_din,
  output logic [2:0]               grant_idx,
  output logic                     busy
);

  sd_arb_state_t         r_state;
  sd_arb_state_t         w_next_state;
  logic [SD_IDX_W-1:0]   r_grant;
  logic [SD_LBA_W-1:0]   r_lba;
  logic [NREQ-1:0]       r_sd_rd;
  logic [NREQ-1:0]       r_sd_wr;
  logic [NREQ-1:0]       r_req_done;

  logic                  w_pick_valid;
  logic [SD_IDX_W-1:0]   w_pick_idx;
  logic [SD_LBA_W-1:0]   w_pick_lba;
  logic                  w_pick_wr;
  logic [NREQ-1:0]       w_pick_oh;
  logic [NREQ-1:0]       w_grant_oh;
  logic                  w_timeout;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_pending (req_rd | req_wr),
    .i_last    (r_grant),
    .o_valid   (w_pick_valid),
    .o_index   (w_pick_idx)
  );

  always_comb begin
    w_pick_lba  = '0;
    w_pick_wr   = 1'b0;
    w_pick_oh   = '0;
    w_grant_oh  = '0;
    sd_buff_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == SD_IDX_W'(i)) begin
        w_pick_lba   = req_lba[i*SD_LBA_W +: SD_LBA_W];
        w_pick_wr    = req_wr[i];
        w_pick_oh[i] = 1'b1;
      end
      if (r_grant == SD_IDX_W'(i)) begin
        w_grant_oh[i] = 1'b1;
        sd_buff_din   = req_buff_din[i*SD_BUF_W +: SD_BUF_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= DRAIN;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      DRAIN: if (!sd_ack) w_next_state = IDLE;
      IDLE:  if (w_pick_valid) w_next_state = ISSUE;
      ISSUE: begin
        if (sd_ack)         w_next_state = XFER;
        else if (w_timeout) w_next_state = DRAIN;
      end
      XFER:  if (!sd_ack) w_next_state = IDLE;
      default: w_next_state = DRAIN;
    endcase
  end

  // When both levels are set the write wins; the read stays pending for a later grant.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_grant    <= '0;
      r_lba      <= '0;
      r_sd_rd    <= '0;
      r_sd_wr    <= '0;
      r_req_done <= '0;
    end else begin
      r_req_done <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_idx;
            r_lba   <= w_pick_lba;
            r_sd_wr <= w_pick_wr ? w_pick_oh : '0;
            r_sd_rd <= w_pick_wr ? '0 : w_pick_oh;
          end
        end
        ISSUE: begin
          if (sd_ack || w_timeout) begin
            r_sd_rd <= '0;
            r_sd_wr <= '0;
          end
          if (!sd_ack && w_timeout) r_req_done <= w_grant_oh;
        end
        XFER: if (!sd_ack) r_req_done <= w_grant_oh;
        default: ;
      endcase
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0]     r_tmo_cnt;
  logic [NREQ-1:0] r_req_err;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_req_err <= '0;
    end else begin
      r_tmo_cnt <= (r_state == ISSUE) ? r_tmo_cnt + 24'd1 : 24'd0;
      r_req_err <= w_timeout ? w_grant_oh : '0;
    end
  end

  assign w_timeout = (r_state == ISSUE) && !sd_ack && (r_tmo_cnt == TIMEOUT_CYC - 24'd1);
  assign req_err   = r_req_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYC;
  assign w_timeout    = 1'b0;
  assign req_err      = '0;
`endif

  // Ack is routed from the first ack cycle (still ISSUE) so the requester sees the whole pulse.
  assign req_ack   = ((r_state == ISSUE) || (r_state == XFER)) ? (w_grant_oh & {NREQ{sd_ack}}) : '0;
  assign req_done  = r_req_done;
  assign sd_lba    = r_lba;
  assign sd_rd     = r_sd_rd;
  assign sd_wr     = r_sd_wr;
  assign grant_idx = r_grant;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sd_blk_arbiter.sv
// Directed self-checking bench for sd_blk_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_sd_blk_arbiter;

  localparam int NREQ = 4;

  logic                 clk_sys = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_rd, req_wr;
  logic [NREQ*32-1:0]   req_lba;
  logic [NREQ*8-1:0]    req_buff_din;
  logic [NREQ-1:0]      req_ack, req_done, req_err;
  logic [31:0]          sd_lba;
  logic [NREQ-1:0]      sd_rd, sd_wr;
  logic                 sd_ack;
  logic [7:0]           sd_buff_din;
  logic [2:0]           grant_idx;
  logic                 busy;

  logic [7:0] buff_tab [NREQ] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

  int n_checks = 0;
  int n_err    = 0;

  sd_blk_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(24'd100)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .req_buff_din (req_buff_din),
    .req_ack      (req_ack),
    .req_done     (req_done),
    .req_err      (req_err),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .grant_idx    (grant_idx),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  // Plays the hps_io side of one transaction and checks the arbiter's view of it.
  task automatic serve(input string tag, input int idx, input bit is_wr, input logic [31:0] lba,
                       input int ack_len, input int exp_lat);
    int k;
    int bad;
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    k  = 0;
    while ((sd_rd | sd_wr) == 4'b0 && k < 50) begin
      step();
      k++;
    end
    check({tag, "_lat"},  k, exp_lat);
    check({tag, "_wr"},   sd_wr, is_wr ? oh : 4'b0);
    check({tag, "_rd"},   sd_rd, is_wr ? 4'b0 : oh);
    check({tag, "_lba"},  sd_lba, lba);
    check({tag, "_gidx"}, grant_idx, idx);
    bad = 0;
    step();
    if ((sd_rd | sd_wr) != oh || sd_buff_din != buff_tab[idx]) bad++;
    sd_ack = 1'b1;
    #1;
    for (int c = 0; c < ack_len; c++) begin
      if (req_ack != oh || sd_buff_din != buff_tab[idx] || req_done != 4'b0) bad++;
      step();
      if ((sd_rd | sd_wr) != 4'b0) bad++;
    end
    check({tag, "_xfer"}, bad, 0);
    sd_ack = 1'b0;
    #1;
    check({tag, "_ack_off"}, req_ack, 4'b0);
    step();
    check({tag, "_done"}, req_done, oh);
    check({tag, "_err"},  req_err, 4'b0);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    sd_ack       = 1'b0;
    req_rd       = '0;
    req_wr       = '0;
    req_lba      = '0;
    req_buff_din = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
    step(2);
    check("rst_sd_rd", sd_rd, 4'b0);
    check("rst_sd_wr", sd_wr, 4'b0);
    check("rst_lba",   sd_lba, 32'h0);
    check("rst_done",  req_done, 4'b0);
    check("rst_err",   req_err, 4'b0);
    check("rst_gidx",  grant_idx, 3'd0);
    check("rst_busy",  busy, 1'b1);
    reset = 1'b0;
    step();
    check("idle_busy", busy, 1'b0);

    // Spurious ack in IDLE
    sd_ack = 1'b1;
    #1;
    check("spur_ack", req_ack, 4'b0);
    step();
    check("spur_busy", busy, 1'b0);
    sd_ack = 1'b0;
    step();

    // Read on requester 2 with a 520-cycle ack
    req_lba[2*32 +: 32] = 32'h1234;
    req_rd[2]           = 1'b1;
    serve("t1", 2, 1'b0, 32'h1234, 520, 1);
    req_rd[2] = 1'b0;
    step();
    check("t1_done_clr", req_done, 4'b0);
    check("t1_idle",     busy, 1'b0);

    // Write on requester 0, buffer data muxed from slice 0
    req_lba[0 +: 32] = 32'hA000;
    req_wr[0]        = 1'b1;
    serve("t5", 0, 1'b1, 32'hA000, 8, 1);
    check("t5_buff", sd_buff_din, 8'hA5);
    req_wr[0] = 1'b0;
    step();

    // All four reads pending with grant_idx=0: order 1,2,3,0 back to back
    for (int i = 0; i < NREQ; i++) req_lba[i*32 +: 32] = 32'h100 + i;
    req_rd = 4'hF;
    serve("t2_1", 1, 1'b0, 32'h101, 3, 1);
    req_rd[1] = 1'b0;
    serve("t2_2", 2, 1'b0, 32'h102, 3, 1);
    req_rd[2] = 1'b0;
    serve("t2_3", 3, 1'b0, 32'h103, 3, 1);
    req_rd[3] = 1'b0;
    serve("t2_0", 0, 1'b0, 32'h100, 3, 1);
    req_rd[0] = 1'b0;
    step();
    check("t2_idle", busy, 1'b0);

    // Read and write together on requester 1: write first, then the read
    req_lba[1*32 +: 32] = 32'h3000;
    req_rd[1]           = 1'b1;
    req_wr[1]           = 1'b1;
    serve("t3_w", 1, 1'b1, 32'h3000, 4, 1);
    req_wr[1] = 1'b0;
    serve("t3_r", 1, 1'b0, 32'h3000, 4, 1);
    req_rd[1] = 1'b0;
    step();

    // Reset during XFER with ack held high
    req_lba[3*32 +: 32] = 32'h44;
    req_rd[3]           = 1'b1;
    step();
    check("t4_issue", sd_rd, 4'b1000);
    sd_ack = 1'b1;
    step(2);
    check("t4_xfer_ack", req_ack, 4'b1000);
    reset  = 1'b1;
    req_rd = '0;
    step();
    check("t4_rst_rd",   sd_rd | sd_wr, 4'b0);
    check("t4_rst_ack",  req_ack, 4'b0);
    check("t4_rst_busy", busy, 1'b1);
    check("t4_rst_gidx", grant_idx, 3'd0);
    check("t4_rst_lba",  sd_lba, 32'h0);
    reset               = 1'b0;
    req_lba[2*32 +: 32] = 32'h55;
    req_rd[2]           = 1'b1;
    step(5);
    check("t4_drain_rd",   sd_rd | sd_wr, 4'b0);
    check("t4_drain_busy", busy, 1'b1);
    check("t4_drain_ack",  req_ack, 4'b0);
    sd_ack = 1'b0;
    serve("t4_new", 2, 1'b0, 32'h55, 4, 2);
    req_rd[2] = 1'b0;
    step();

`ifdef SD_ARB_TIMEOUT_EN
    // No ack: abort after 100 strobe cycles, then a late ack is absorbed
    req_lba[1*32 +: 32] = 32'h77;
    req_rd[1]           = 1'b1;
    step();
    check("t6_issue", sd_rd, 4'b0010);
    n = 1;
    while (sd_rd != 4'b0 && n < 300) begin
      step();
      if (sd_rd != 4'b0) n++;
    end
    check("t6_len",  n, 100);
    check("t6_done", req_done, 4'b0010);
    check("t6_err",  req_err, 4'b0010);
    check("t6_busy", busy, 1'b1);
    req_rd[1] = 1'b0;
    sd_ack    = 1'b1;
    #1;
    check("t6_late_ack", req_ack, 4'b0);
    step();
    check("t6_late_ack2", req_ack, 4'b0);
    check("t6_drain",     busy, 1'b1);
    check("t6_done_clr",  req_done | req_err, 4'b0);
    step(3);
    sd_ack = 1'b0;
    step();
    check("t6_idle", busy, 1'b0);
`else
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (req_err != 4'b0) n++;
      step();
    end
    check("no_tmo_err", n, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
